// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding
// and forwarding-select encoding used on the fwd_E outputs.
package hazard_pkg;

  localparam int HZ_STATE_W = 2;
  localparam int FWD_SEL_W  = 2;

  typedef enum logic [HZ_STATE_W-1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MC_WAIT  = 2'd2
  } hz_state_e;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-result scoreboard for multi-cycle operations. One bit per
// architectural register marks a result that has not reached the register
// file yet; D-stage source addresses are looked up against it.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            set_en,
  input  logic [REG_AW-1:0]               set_rd,
  input  logic                            clr_en,
  input  logic [REG_AW-1:0]               clr_rd,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]  lookup_rs,
  output logic [NUM_SRC-1:0]              lookup_hit
);

  localparam int NUM_REGS = 2**REG_AW;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Next pending vector: clear first so a same-cycle set on the same
  // register wins; x0 can never be pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != '0)) begin
      pending_d[set_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending register; reset discards all outstanding multi-cycle results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Per-source lookup uses the registered vector, so a clear in this cycle
  // still reads as pending until the next edge.
  always_comb begin
    lookup_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lookup_hit[i] = (lookup_rs[i] != '0) && pending_q[lookup_rs[i]];
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: operand forwarding,
// load-use and multi-cycle scoreboard stalls, branch flushes, and a
// saturating count of stalled cycles.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0][REG_AW-1:0] rs_D,
  input  logic [NUM_SRC-1:0][REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0]              rs2_M,
  input  logic [REG_AW-1:0]              rd_E,
  input  logic [REG_AW-1:0]              rd_M,
  input  logic [REG_AW-1:0]              rd_W,
  input  logic                           reg_wr_E,
  input  logic                           reg_wr_M,
  input  logic                           reg_wr_W,
  input  logic                           load_E,
  input  logic                           mc_issue_E,
  input  logic                           mc_done,
  input  logic [REG_AW-1:0]              mc_rd,
  input  logic                           branch_taken_E,
  input  logic                           cnt_clr,
  output logic [NUM_SRC-1:0][1:0]        fwd_E,
  output logic                           fwd_M,
  output logic                           stall_F,
  output logic                           stall_D,
  output logic                           flush_D,
  output logic                           flush_E,
  output logic [1:0]                     hz_state,
  output logic [CNT_W-1:0]               stall_cnt
);

  hz_state_e          state_q;
  hz_state_e          state_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;
  logic [NUM_SRC-1:0] sb_hit;
  logic               lu;
  logic               sb;

  hazard_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (mc_issue_E),
    .set_rd     (rd_E),
    .clr_en     (mc_done),
    .clr_rd     (mc_rd),
    .lookup_rs  (rs_D),
    .lookup_hit (sb_hit)
  );

  // Forwarding selects per E-stage source; the younger M result beats W,
  // x0 always reads the register file, and reset forces the RF path.
  always_comb begin
    fwd_E = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_E[i] = FWD_RF;
      if (rst_n && (rs_E[i] != '0)) begin
        if (reg_wr_M && (rs_E[i] == rd_M)) begin
          fwd_E[i] = FWD_M;
        end else if (reg_wr_W && (rs_E[i] == rd_W)) begin
          fwd_E[i] = FWD_W;
        end
      end
    end
    fwd_M = rst_n && reg_wr_W && (rd_W != '0) && (rs2_M == rd_W);
  end

  // Hazard detection: a load in E feeding any D source, or any D source
  // still waiting on a multi-cycle result.
  always_comb begin
    lu = 1'b0;
    if (load_E && reg_wr_E && (rd_E != '0)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rs_D[i] == rd_E) begin
          lu = 1'b1;
        end
      end
    end
    sb = |sb_hit;
  end

  // Pipeline controls; a taken branch kills the stalled instruction so the
  // stall is dropped in favour of the flush.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (rst_n) begin
      stall_F = (lu || sb) && !branch_taken_E;
      stall_D = (lu || sb) && !branch_taken_E;
      flush_D = branch_taken_E;
      flush_E = lu || sb || branch_taken_E;
    end
  end

  // Next-state logic; load-use outranks the scoreboard and a taken branch
  // always returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (lu) begin
          state_d = LU_STALL;
        end else if (sb) begin
          state_d = MC_WAIT;
        end
      end
      LU_STALL: begin
        state_d = RUN;
      end
      MC_WAIT: begin
        state_d = sb ? MC_WAIT : RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (branch_taken_E) begin
      state_d = RUN;
    end
  end

  // Stall counter: clear wins, otherwise count stalled cycles up to all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall_D && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz_state  = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (NUM_SRC=2, REG_AW=5, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// one further unit later, well away from the next edge.
module tb_hazard_ctrl;

  logic            clk;
  logic            rst_n;
  logic [1:0][4:0] rs_D;
  logic [1:0][4:0] rs_E;
  logic [4:0]      rs2_M, rd_E, rd_M, rd_W, mc_rd;
  logic            reg_wr_E, reg_wr_M, reg_wr_W;
  logic            load_E, mc_issue_E, mc_done, branch_taken_E, cnt_clr;
  logic [1:0][1:0] fwd_E;
  logic            fwd_M, stall_F, stall_D, flush_D, flush_E;
  logic [1:0]      hz_state;
  logic [3:0]      stall_cnt;

  int n_compared;
  int n_mismatched;

  hazard_ctrl #(
    .NUM_SRC (2),
    .REG_AW  (5),
    .CNT_W   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_D           (rs_D),
    .rs_E           (rs_E),
    .rs2_M          (rs2_M),
    .rd_E           (rd_E),
    .rd_M           (rd_M),
    .rd_W           (rd_W),
    .reg_wr_E       (reg_wr_E),
    .reg_wr_M       (reg_wr_M),
    .reg_wr_W       (reg_wr_W),
    .load_E         (load_E),
    .mc_issue_E     (mc_issue_E),
    .mc_done        (mc_done),
    .mc_rd          (mc_rd),
    .branch_taken_E (branch_taken_E),
    .cnt_clr        (cnt_clr),
    .fwd_E          (fwd_E),
    .fwd_M          (fwd_M),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .hz_state       (hz_state),
    .stall_cnt      (stall_cnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return every data input to an idle value.
  task automatic clear_inputs();
    rs_D = '0; rs_E = '0; rs2_M = '0; rd_E = '0; rd_M = '0; rd_W = '0; mc_rd = '0;
    reg_wr_E = 0; reg_wr_M = 0; reg_wr_W = 0; load_E = 0; mc_issue_E = 0;
    mc_done = 0; branch_taken_E = 0; cnt_clr = 0;
  endtask

  // Reset gating of outputs and reset values of state and counter.
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    load_E = 1; reg_wr_E = 1; rd_E = 5'd7; rs_D[0] = 5'd7;
    rs_E[0] = 5'd5; rd_M = 5'd5; reg_wr_M = 1; rs2_M = 5'd3; rd_W = 5'd3; reg_wr_W = 1;
    branch_taken_E = 1;
    #1;
    n_compared++;
    if ({stall_F, stall_D, flush_D, flush_E} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ctrl got %b want 0000", {stall_F, stall_D, flush_D, flush_E});
    end
    n_compared++;
    if ({fwd_E, fwd_M} !== 5'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_fwd got %b want 00000", {fwd_E, fwd_M});
    end
    tick(); tick();
    n_compared++;
    if (hz_state !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state got %0d want 0", hz_state);
    end
    n_compared++;
    if (stall_cnt !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_cnt got %0d want 0", stall_cnt);
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  // Forwarding priority, x0 suppression and store-data forwarding.
  task automatic test_forwarding();
    clear_inputs();
    rs_E[0] = 5'd5; rd_M = 5'd5; reg_wr_M = 1; rd_W = 5'd5; reg_wr_W = 1;
    #1;
    n_compared++;
    if (fwd_E[0] !== 2'b11) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_m_prio got %b want 11", fwd_E[0]);
    end
    rs_E[0] = 5'd0;
    #1;
    n_compared++;
    if (fwd_E[0] !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_x0 got %b want 00", fwd_E[0]);
    end
    rs_E[0] = 5'd5; reg_wr_M = 0;
    rs_E[1] = 5'd6;
    #1;
    n_compared++;
    if (fwd_E !== 4'b00_01) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_w_only got %b want 0001", fwd_E);
    end
    rd_W = 5'd6; rd_M = 5'd5; reg_wr_M = 1;
    #1;
    n_compared++;
    if (fwd_E !== 4'b01_11) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_both_src got %b want 0111", fwd_E);
    end
    rs2_M = 5'd6;
    #1;
    n_compared++;
    if (fwd_M !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_m_store got %b want 1", fwd_M);
    end
    rs2_M = 5'd0; rd_W = 5'd0;
    #1;
    n_compared++;
    if (fwd_M !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_m_x0 got %b want 0", fwd_M);
    end
    clear_inputs();
  endtask

  // Load-use stall for one cycle, then LU_STALL state with stalls released.
  task automatic test_load_use();
    clear_inputs();
    load_E = 1; rd_E = 5'd7; reg_wr_E = 1; rs_D[1] = 5'd7;
    #1;
    n_compared++;
    if ({stall_F, stall_D, flush_E, flush_D} !== 4'b1110) begin
      n_mismatched++;
      $display("[TB] FAIL lu_ctrl got %b want 1110", {stall_F, stall_D, flush_E, flush_D});
    end
    tick();
    clear_inputs();
    #1;
    n_compared++;
    if (hz_state !== 2'd1) begin
      n_mismatched++;
      $display("[TB] FAIL lu_state got %0d want 1", hz_state);
    end
    n_compared++;
    if ({stall_F, stall_D} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL lu_release got %b want 00", {stall_F, stall_D});
    end
    n_compared++;
    if (stall_cnt !== 4'd1) begin
      n_mismatched++;
      $display("[TB] FAIL lu_cnt got %0d want 1", stall_cnt);
    end
    tick();
    n_compared++;
    if (hz_state !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL lu_return got %0d want 0", hz_state);
    end
  endtask

  // Multi-cycle issue at cycle 0, consumer from cycle 6, completion at 10.
  task automatic test_multicycle();
    clear_inputs();
    mc_issue_E = 1; rd_E = 5'd9; rs_D[0] = 5'd9;
    #1;
    n_compared++;
    if (stall_D !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mc_issue_cycle got %b want 0", stall_D);
    end
    tick();
    clear_inputs();
    repeat (5) tick();
    rs_D[0] = 5'd9;
    #1;
    n_compared++;
    if ({stall_D, hz_state} !== 3'b1_00) begin
      n_mismatched++;
      $display("[TB] FAIL mc_first_stall got %b want 100", {stall_D, hz_state});
    end
    for (int c = 7; c <= 9; c++) begin
      tick();
      n_compared++;
      if ({stall_D, hz_state} !== 3'b1_10) begin
        n_mismatched++;
        $display("[TB] FAIL mc_wait_c%0d got %b want 110", c, {stall_D, hz_state});
      end
    end
    tick();
    mc_done = 1; mc_rd = 5'd9;
    #1;
    n_compared++;
    if (stall_D !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mc_done_cycle got %b want 1", stall_D);
    end
    tick();
    mc_done = 0; mc_rd = 5'd0;
    #1;
    n_compared++;
    if ({stall_D, hz_state} !== 3'b0_10) begin
      n_mismatched++;
      $display("[TB] FAIL mc_release got %b want 010", {stall_D, hz_state});
    end
    n_compared++;
    if (stall_cnt !== 4'd6) begin
      n_mismatched++;
      $display("[TB] FAIL mc_cnt got %0d want 6", stall_cnt);
    end
    tick();
    n_compared++;
    if (hz_state !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL mc_return got %0d want 0", hz_state);
    end
    clear_inputs();
  endtask

  // Taken branch overrides a load-use hit.
  task automatic test_branch();
    clear_inputs();
    load_E = 1; rd_E = 5'd7; reg_wr_E = 1; rs_D[0] = 5'd7; branch_taken_E = 1;
    #1;
    n_compared++;
    if ({flush_D, flush_E, stall_F, stall_D} !== 4'b1100) begin
      n_mismatched++;
      $display("[TB] FAIL br_ctrl got %b want 1100", {flush_D, flush_E, stall_F, stall_D});
    end
    tick();
    clear_inputs();
    #1;
    n_compared++;
    if ({hz_state, stall_cnt} !== {2'd0, 4'd6}) begin
      n_mismatched++;
      $display("[TB] FAIL br_next got state %0d cnt %0d want state 0 cnt 6", hz_state, stall_cnt);
    end
  endtask

  // Same-cycle set and clear of one register: set wins.
  task automatic test_same_cycle();
    clear_inputs();
    mc_issue_E = 1; rd_E = 5'd4; mc_done = 1; mc_rd = 5'd4;
    rs2_M = 5'd3; rd_W = 5'd3; reg_wr_W = 1;
    #1;
    n_compared++;
    if (fwd_M !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL sc_fwd_m got %b want 1", fwd_M);
    end
    tick();
    clear_inputs();
    rs_D[0] = 5'd4; mc_done = 1; mc_rd = 5'd4;
    #1;
    n_compared++;
    if (stall_D !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL sc_pending got %b want 1", stall_D);
    end
    tick();
    mc_done = 0; mc_rd = 5'd0;
    #1;
    n_compared++;
    if ({stall_D, hz_state, stall_cnt} !== {1'b0, 2'd2, 4'd7}) begin
      n_mismatched++;
      $display("[TB] FAIL sc_cleared got %b want 0_10_0111", {stall_D, hz_state, stall_cnt});
    end
    clear_inputs();
    tick();
    n_compared++;
    if (hz_state !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL sc_return got %0d want 0", hz_state);
    end
  endtask

  // Counter saturation, clear priority, then reset in the middle of MC_WAIT.
  task automatic test_saturate_and_reset();
    clear_inputs();
    mc_issue_E = 1; rd_E = 5'd10;
    tick();
    clear_inputs();
    rs_D[0] = 5'd10;
    repeat (12) tick();
    n_compared++;
    if ({hz_state, stall_cnt} !== {2'd2, 4'd15}) begin
      n_mismatched++;
      $display("[TB] FAIL sat_hold got state %0d cnt %0d want state 2 cnt 15", hz_state, stall_cnt);
    end
    cnt_clr = 1;
    tick();
    n_compared++;
    if (stall_cnt !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL cnt_clr got %0d want 0", stall_cnt);
    end
    cnt_clr = 0;
    tick();
    n_compared++;
    if (stall_cnt !== 4'd1) begin
      n_mismatched++;
      $display("[TB] FAIL cnt_after_clr got %0d want 1", stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({stall_F, stall_D, flush_E, flush_D} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_ctrl got %b want 0000", {stall_F, stall_D, flush_E, flush_D});
    end
    tick();
    n_compared++;
    if ({hz_state, stall_cnt} !== {2'd0, 4'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_state got state %0d cnt %0d want 0 0", hz_state, stall_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_compared++;
    if (stall_D !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_sb_discard got %b want 0", stall_D);
    end
    clear_inputs();
  endtask

  // Run all scenarios in order and report.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_branch();
    test_same_cycle();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
